// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding and response error codes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } mem_rsp_state_t;

  localparam logic RSP_ERR_NONE   = 1'b0;
  localparam logic RSP_ERR_ACCESS = 1'b1;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/sram_bank.sv
// Single-port synchronous SRAM with per-byte write enables; contents are not reset.
// Simulation preload can target mem_q hierarchically.
module sram_bank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH/8-1:0] be_i,
  output logic [WIDTH-1:0]   rdata_o
);

  localparam int unsigned BYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < int'(BYTES); b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store, waits WAIT_STATES cycles,
// accesses the SRAM bank, then holds a registered response until the core takes it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
);

  localparam int unsigned BYTES   = WIDTH / 8;
  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  mem_rsp_state_t          state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [WIDTH-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [BYTES-1:0]        be_q, be_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0]        idx_c;
  logic                    err_c;
  logic                    sram_en_c;
  logic [WIDTH-1:0]        sram_rdata_c;

  // Address decode from the held request: word index, alignment and range.
  always_comb begin
    idx_c = addr_q / WIDTH'(BYTES);
    err_c = ((addr_q % WIDTH'(BYTES)) != '0) || (idx_c >= WIDTH'(DEPTH_WORDS));
  end

  assign sram_en_c = (state_q == ACCESS) && !err_c;

  sram_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_en_c),
    .we_i    (we_q),
    .addr_i  (idx_c[AW-1:0]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (sram_rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RSP_ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WS_LOAD);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d = RESPOND;
      end
      RESPOND: begin
        // First RESPOND cycle registers the SRAM output; afterwards hold until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c ? RSP_ERR_ACCESS : RSP_ERR_NONE;
          rsp_rdata_d = (err_c || we_q) ? '0 : sram_rdata_c;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = RSP_ERR_NONE;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
